// File: rtl/jt51_pkg.sv
// Shared definitions for the JT51 write sequencer.
// Contents: sequencer state enum, request entry layout, register-number
// constants for the chip's address map and a register-class helper.
package jt51_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_AGAP,
    ST_DATA,
    ST_DGAP,
    ST_BWAIT
  } wrseq_state_t;

  // One queued register write: 16 bits, register number in the upper byte.
  typedef struct packed {
    logic [7:0] addr;
    logic [7:0] data;
  } wr_req_t;

  localparam logic [7:0] REG_TEST   = 8'h01;
  localparam logic [7:0] REG_KON    = 8'h08;
  localparam logic [7:0] REG_NOISE  = 8'h0F;
  localparam logic [7:0] REG_GLB_LO = 8'h10;
  localparam logic [7:0] REG_GLB_HI = 8'h1B;
  localparam logic [7:0] REG_OP_LO  = 8'h20;
  localparam logic [7:0] REG_OP_HI  = 8'hFF;

  // True for the per-channel / per-operator register region.
  function automatic logic is_op_reg(input logic [7:0] a);
    return (a >= REG_OP_LO) && (a <= REG_OP_HI);
  endfunction

endpackage

// File: rtl/jt51_wrfifo.sv
// Synchronous request FIFO for the write sequencer.
// Ports: clk_i/rst_i (sync, active high), push_i/wdata_i write side,
// pop_i read side, head_o = oldest entry, ready_o = not full,
// empty_o, level_o = occupancy (0..DEPTH).
module jt51_wrfifo
  import jt51_pkg::*;
#(
  parameter int unsigned DEPTH = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     push_i,
  input  wr_req_t                  wdata_i,
  input  logic                     pop_i,
  output wr_req_t                  head_o,
  output logic                     ready_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   level_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;

  wr_req_t          mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [LW-1:0]    level_q;
  logic             do_push;
  logic             do_pop;

  // Readiness depends on level only, so a pop never frees a slot for a
  // push in the same cycle.
  assign ready_o = (level_q != LW'(DEPTH));
  assign empty_o = (level_q == '0);
  assign level_o = level_q;
  assign head_o  = mem_q[rd_ptr_q];
  assign do_push = push_i && ready_o;
  assign do_pop  = pop_i && !empty_o;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      if (do_push && !do_pop)      level_q <= level_q + LW'(1);
      else if (do_pop && !do_push) level_q <= level_q - LW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/jt51_wrseq.sv
// JT51 register write sequencer.
// Queues (register, value) requests and replays them onto the chip bus as
// an address access (a0=0) followed by a data access (a0=1), skipping the
// address access when the register is already selected. After each data
// access it waits for the chip busy flag, with a timeout.
// Ports: clk, rst (sync, active high); req_valid/req_ready/req_addr/req_data
// request side; dout/a0/write/busy chip side; idle, tmo_err, level status.
module jt51_wrseq
  import jt51_pkg::*;
#(
  parameter int unsigned DEPTH    = 8,
  parameter int unsigned WR_LEN   = 2,
  parameter int unsigned GAP      = 1,
  parameter int unsigned BUSY_TMO = 1023
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic [7:0]             req_addr,
  input  logic [7:0]             req_data,
  output logic [7:0]             dout,
  output logic                   a0,
  output logic                   write,
  input  logic                   busy,
  output logic                   idle,
  output logic                   tmo_err,
  output logic [$clog2(DEPTH):0] level
);

  localparam int unsigned CW = $clog2(BUSY_TMO + WR_LEN + GAP + 1);
  localparam logic [CW-1:0] LEN_LAST = CW'(WR_LEN - 1);
  localparam logic [CW-1:0] GAP_LAST = CW'(GAP - 1);
  localparam logic [CW-1:0] TMO_LAST = CW'(BUSY_TMO - 1);
  localparam logic [CW-1:0] BUSY_IGN = CW'(2);

  wrseq_state_t state_q;
  logic [CW-1:0] cnt_q;
  logic [7:0]    dout_q;
  logic          a0_q;
  logic          write_q;
  logic          tmo_q;
  logic [7:0]    last_addr_q;
  logic          last_valid_q;

  wr_req_t       head;
  logic          fifo_empty;
  logic          pop;

  assign pop = (state_q == ST_DATA) && (cnt_q == LEN_LAST);

  jt51_wrfifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk_i   (clk),
    .rst_i   (rst),
    .push_i  (req_valid),
    .wdata_i ({req_addr, req_data}),
    .pop_i   (pop),
    .head_o  (head),
    .ready_o (req_ready),
    .empty_o (fifo_empty),
    .level_o (level)
  );

  assign dout    = dout_q;
  assign a0      = a0_q;
  assign write   = write_q;
  assign tmo_err = tmo_q;
  assign idle    = fifo_empty && (state_q == ST_IDLE);

  // Bus outputs are loaded only on the edge that raises write or in the gap
  // states, so dout/a0 never move while write is high.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      dout_q       <= '0;
      a0_q         <= 1'b0;
      write_q      <= 1'b0;
      tmo_q        <= 1'b0;
      last_addr_q  <= '0;
      last_valid_q <= 1'b0;
    end else begin
      tmo_q <= 1'b0;
      cnt_q <= cnt_q + CW'(1);
      case (state_q)
        ST_IDLE: begin
          if (!fifo_empty) begin
            cnt_q   <= '0;
            write_q <= 1'b1;
            if (last_valid_q && (head.addr == last_addr_q)) begin
              state_q <= ST_DATA;
              a0_q    <= 1'b1;
              dout_q  <= head.data;
            end else begin
              state_q <= ST_ADDR;
              a0_q    <= 1'b0;
              dout_q  <= head.addr;
            end
          end
        end
        ST_ADDR: begin
          if (cnt_q == LEN_LAST) begin
            state_q      <= ST_AGAP;
            cnt_q        <= '0;
            write_q      <= 1'b0;
            last_addr_q  <= head.addr;
            last_valid_q <= 1'b1;
          end
        end
        ST_AGAP: begin
          if (cnt_q == GAP_LAST) begin
            state_q <= ST_DATA;
            cnt_q   <= '0;
            write_q <= 1'b1;
            a0_q    <= 1'b1;
            dout_q  <= head.data;
          end
        end
        ST_DATA: begin
          if (cnt_q == LEN_LAST) begin
            state_q <= ST_DGAP;
            cnt_q   <= '0;
            write_q <= 1'b0;
          end
        end
        ST_DGAP: begin
          if (cnt_q == GAP_LAST) begin
            state_q <= ST_BWAIT;
            cnt_q   <= '0;
          end
        end
        ST_BWAIT: begin
          // The chip raises busy a cycle after the write edge, so the first
          // two cycles here say nothing about the finished access.
          if ((cnt_q >= BUSY_IGN) && !busy) begin
            state_q <= ST_IDLE;
          end else if (cnt_q == TMO_LAST) begin
            state_q      <= ST_IDLE;
            tmo_q        <= 1'b1;
            last_valid_q <= 1'b0;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule
